// File: rtl/barrel_shifter_pipe_if.sv
// Handshake/data bundle for barrel_shifter_pipe: operand channel in, result channel out.
// WIDTH must match the shifter instance; SHW follows from it.
interface barrel_shifter_pipe_if #(
    parameter int unsigned WIDTH = 8
);
    localparam int unsigned SHW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   in_amt;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, in_amt, in_mode, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_amt, in_mode, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/barrel_shifter_pipe.sv
// Pipelined log-stage barrel shifter (SRL/SLL/SRA, optional ROR) with valid/ready flow control.
// Define BARREL_SHIFTER_PIPE_ROTATE_EN to build the ROR mode; otherwise mode 11 decodes as SRL.
module barrel_shifter_pipe #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    barrel_shifter_pipe_if.slave  bus
);
    localparam int unsigned SHW = $clog2(WIDTH);

    // Stage registers; index 0 is the first stage (handles amt bit SHW-1).
    logic [SHW-1:0]   vld_q;
    logic [WIDTH-1:0] data_q [SHW];
    logic [SHW-1:0]   amt_q  [SHW];
    logic [1:0]       mode_q [SHW];

    logic [SHW-1:0]   adv;
    logic             go;
    logic [SHW-1:0]   src_vld;
    logic [WIDTH-1:0] src_data [SHW];
    logic [SHW-1:0]   src_amt  [SHW];
    logic [1:0]       src_mode [SHW];
    logic [WIDTH-1:0] shf_data [SHW];
    logic [SHW-1:0]   nxt_amt  [SHW];

    function automatic logic [WIDTH-1:0] stage_shift(input logic [WIDTH-1:0] d,
                                                     input logic [1:0] mode,
                                                     input int unsigned sh);
        logic [WIDTH-1:0] r;
        case (mode)
            2'b01:   r = d << sh;
            // Once SRA has shifted, the MSB already holds the original sign bit.
            2'b10:   r = $unsigned($signed(d) >>> sh);
`ifdef BARREL_SHIFTER_PIPE_ROTATE_EN
            2'b11:   r = (d >> sh) | (d << (WIDTH - sh));
`endif
            default: r = d >> sh;
        endcase
        return r;
    endfunction

    // Ready chain: a stage moves if it or any stage downstream has a hole, or the sink pops.
    always_comb begin
        adv = '0;
        go  = bus.out_ready;
        for (int i = SHW - 1; i >= 0; i--) begin
            go     = go | ~vld_q[i];
            adv[i] = go;
        end
    end

    always_comb begin
        src_vld     = '0;
        src_vld[0]  = bus.in_valid;
        src_data[0] = bus.in_data;
        src_amt[0]  = bus.in_amt;
        src_mode[0] = bus.in_mode;
        for (int i = 1; i < SHW; i++) begin
            src_vld[i]  = vld_q[i-1];
            src_data[i] = data_q[i-1];
            src_amt[i]  = amt_q[i-1];
            src_mode[i] = mode_q[i-1];
        end
        for (int i = 0; i < SHW; i++) begin
            shf_data[i] = src_data[i];
            if (src_amt[i][SHW-1-i]) begin
                shf_data[i] = stage_shift(src_data[i], src_mode[i], 1 << (SHW - 1 - i));
            end
            nxt_amt[i]           = src_amt[i];
            nxt_amt[i][SHW-1-i]  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < SHW; i++) begin
                data_q[i] <= '0;
                amt_q[i]  <= '0;
                mode_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < SHW; i++) begin
                if (adv[i]) begin
                    vld_q[i] <= src_vld[i];
                    if (src_vld[i]) begin
                        data_q[i] <= shf_data[i];
                        amt_q[i]  <= nxt_amt[i];
                        mode_q[i] <= src_mode[i];
                    end
                end
            end
        end
    end

    assign bus.in_ready  = adv[0];
    assign bus.out_valid = vld_q[SHW-1];
    assign bus.out_data  = data_q[SHW-1];
endmodule

// File: doc/barrel_shifter_pipe.md
BARREL_SHIFTER_PIPE -- requirements
Module: barrel_shifter_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data width; power of two, at least 2.
REQ-002 SHALL derive local constant SHW = log2(WIDTH), which sets the shift-amount width and the stage count.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: the input operand is valid.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts an operand this cycle.
REQ-007 SHALL have port in_data, input, WIDTH bits: operand.
REQ-008 SHALL have port in_amt, input, SHW bits: shift amount, 0..WIDTH-1.
REQ-009 SHALL have port in_mode, input, 2 bits: 00 SRL, 01 SLL, 10 SRA, 11 ROR.
REQ-010 SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-011 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-012 SHALL have port out_data, output, WIDTH bits: shifted result.

Function
REQ-013 SHALL implement SHW cascaded 2:1-mux stages; stage k (k = SHW-1 down to 0) shifts by 2^k when amt bit k = 1, MSB stage first.
REQ-014 SHALL place a register after every stage holding data, remaining amt, mode and a valid bit; latency in_valid&&in_ready -> out_valid = SHW cycles with no stall.
REQ-015 SHALL define SRL fill as zero from the MSB side and SLL fill as zero from the LSB side.
REQ-016 SHALL define SRA fill as copies of the original in_data[WIDTH-1].
REQ-017 SHALL define ROR so that bits leaving LSB re-enter at MSB.
REQ-018 SHALL pass data unchanged through every stage for amt = 0 in any mode.
REQ-019 SHALL advance stage k when stage k is empty or stage k+1 advances; the last stage advances when out_valid=0 or out_ready=1.
REQ-020 SHALL drive in_ready = first stage empty or first stage advancing (combinational ready chain, no skid buffer).
REQ-021 SHALL hold out_data/out_valid stable while out_valid=1 and out_ready=0.
REQ-022 SHALL provide full throughput of one result per cycle when out_ready is held at 1.
REQ-023 SHALL let a full pipeline of SHW items under stall accept a new item in the same cycle out_ready rises (simultaneous pop and push).
REQ-024 SHALL preserve order; no item is dropped or duplicated.
REQ-025 SHALL ignore in_data/in_amt/in_mode when in_valid=0 or in_ready=0.

Reset
REQ-026 SHALL clear all stage valid bits on rst_n low immediately (asynchronously), including mid-operation; in-flight items are discarded.
REQ-027 SHALL reset out_valid=0, out_data=0, and all stage data/amt/mode registers to 0.
REQ-028 SHALL have in_ready=1 from the first rising edge after rst_n deasserts.

Configuration
REQ-029 SHALL compile the ROR mode only when macro BARREL_SHIFTER_PIPE_ROTATE_EN is defined.
REQ-030 SHALL, without BARREL_SHIFTER_PIPE_ROTATE_EN, decode in_mode 11 as SRL, with no rotate wrap logic present.

Verification (WIDTH=8, SHW=3)
REQ-031 SHALL cover: 0x80, SRL, amt 4 -> out_data 0x08 exactly 3 cycles after acceptance.
REQ-032 SHALL cover: 0x80, SRA, amt 7 -> 0xFF; 0x70, SRA, amt 4 -> 0x07.
REQ-033 SHALL cover: 0x81, ROR, amt 1 -> 0xC0 with macro defined; same stimulus -> 0x40 without the macro. SLL 0x01, amt 3 -> 0x08.
REQ-034 SHALL cover: out_ready=0 while streaming 0x01..0x05 with SLL amt 1 -> in_ready drops after 3 accepted; release -> 0x02,0x04,0x06,0x08,0x0A in order, one per cycle.
REQ-035 SHALL cover: rst_n pulsed low with 2 items in flight -> out_valid=0 at once, nothing emitted after release; the next item's result is correct.
